// File: rtl/ndn_pkg.sv
// Shared constants for the NDN SPI transmit path: packet lengths, grant encodings
// and the transmit-arbiter state encoding.
package ndn_pkg;

   localparam int INTEREST_BYTES = 9;
   localparam int DATA_BYTES     = 41;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_FIB  = 2'b01;
   localparam logic [1:0] GNT_PIT  = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t SEND = 2'd1;
   localparam state_t GAP  = 2'd2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the pointer
// decides (ptr = 0 favours FIB, ptr = 1 favours PIT).
module rr_arbiter2
   import ndn_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = GNT_NONE;
      if (req == 2'b11)
         grant = ptr ? GNT_PIT : GNT_FIB;
      else if (req[0])
         grant = GNT_FIB;
      else if (req[1])
         grant = GNT_PIT;
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Whole-packet round-robin arbiter sharing the SPI TX byte stream between FIB and PIT.
// Define SPI_TX_TIMEOUT_EN to build the stall timeout that aborts a stuck packet.
//
// state | meaning
// IDLE  | no owner; pick a requester, register grant
// SEND  | owner's bytes pass straight through to SPI until the packet length is reached
// GAP   | grant cleared; idle GAP_CYCLES cycles before re-arbitrating
module spi_tx_arbiter
   import ndn_pkg::*;
#(
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fib_req,
   input  logic [7:0] fib_data,
   output logic       fib_ready,
   input  logic       pit_req,
   input  logic [7:0] pit_data,
   output logic       pit_ready,
   input  logic       spi_tx_ready,
   output logic       spi_tx_valid,
   output logic [7:0] spi_tx_data,
   output logic [1:0] grant,
   output logic       pkt_done,
   output logic       abort
);

   state_t     state;
   logic [1:0] grant_q;
   logic [5:0] byte_cnt;
   logic [3:0] gap_cnt;
   logic       ptr;

   logic [1:0] pick;
   logic       in_send;
   logic       owner_req;
   logic [7:0] owner_data;
   logic [5:0] pkt_len;
   logic       xfer;
   logic       last_byte;
   logic       timeout;

   rr_arbiter2 u_rr (
      .req   ({pit_req, fib_req}),
      .ptr   (ptr),
      .grant (pick)
   );

   always_comb begin
      owner_req  = (grant_q[0] & fib_req) | (grant_q[1] & pit_req);
      owner_data = grant_q[1] ? pit_data : (grant_q[0] ? fib_data : 8'h00);
      pkt_len    = grant_q[1] ? 6'(DATA_BYTES) : 6'(INTEREST_BYTES);
      in_send    = (state == SEND);
      xfer       = in_send && owner_req && spi_tx_ready;
      last_byte  = (byte_cnt == pkt_len - 6'd1);
   end

   assign grant        = grant_q;
   assign spi_tx_valid = in_send && owner_req;
   assign spi_tx_data  = owner_data;
   assign fib_ready    = in_send && grant_q[0] && spi_tx_ready;
   assign pit_ready    = in_send && grant_q[1] && spi_tx_ready;
   assign pkt_done     = xfer && last_byte;

`ifdef SPI_TX_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall_cnt;
   logic               stall;

   // Only a missing owner byte is a stall; SPI backpressure never is.
   assign stall   = in_send && !owner_req;
   assign timeout = stall && (stall_cnt == '0);
   assign abort   = timeout;

   always_ff @(posedge clk) begin
      if (rst || !stall)
         stall_cnt <= STALL_W'(TIMEOUT_CYCLES - 1);
      else
         stall_cnt <= stall_cnt - 1'b1;
   end
`else
   assign timeout = 1'b0;
   assign abort   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant_q  <= GNT_NONE;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         ptr      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick != GNT_NONE) begin
                  grant_q <= pick;
                  state   <= SEND;
               end
            end
            SEND: begin
               // Completion and abort both hand the next tie to the other source.
               if (timeout || (xfer && last_byte)) begin
                  byte_cnt <= '0;
                  ptr      <= grant_q[0];
                  grant_q  <= GNT_NONE;
                  gap_cnt  <= 4'(GAP_CYCLES - 1);
                  state    <= GAP;
               end else if (xfer) begin
                  byte_cnt <= byte_cnt + 6'd1;
               end
            end
            GAP: begin
               if (gap_cnt == '0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
